// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared types and encodings for the multicycle MIPS controller:
//   state_t     main FSM states (4-bit encoding)
//   aluop_t     ALU operation class handed from the FSM to the ALU decoder
//   OP_*        IR[31:26] opcodes recognised by the controller
//   FN_*        IR[5:0] R-type function codes
//   ALU_*       alucontrol encodings driven to the ALU
// ---------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEX,
    ADDIWB,
    JUMP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_alu_ctl.sv
// ---------------------------------------------------------------------------
// mc_alu_ctl
// Combinational ALU decoder: maps the FSM's aluop class plus the R-type funct
// field onto the ALU control code.
//   aluop_i       in   aluop_t  operation class from the FSM
//   funct_i       in   6        IR[5:0]
//   alucontrol_o  out  3        ALU operation select
//   bad_funct_o   out  1        funct not supported (only meaningful for ALUOP_FUNCT)
// ---------------------------------------------------------------------------
module mc_alu_ctl
  import mc_pkg::*;
(
  input  aluop_t      aluop_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alucontrol_o,
  output logic        bad_funct_o
);

  always_comb begin
    // NOTE: every output is given a default before the case so no path can infer a latch.
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          // Unsupported funct still computes an add so the datapath stays benign.
          default: bad_funct_o  = 1'b1;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Control unit for the multicycle MIPS core. A Moore main FSM sequences the
// shared ALU, memory port, IR, PC and register file one micro-step per cycle;
// mc_alu_ctl turns the FSM's aluop into the ALU control code.
//
// Optional feature macro: MC_BNE_EN
//   defined   : opcode 000101 (bne) is executed; branch taken on ~zero.
//   undefined : opcode 000101 is illegal; branch taken on zero only.
//
// Ports
//   clk         in   1      clock, rising edge
//   reset       in   1      asynchronous active-high; forces FETCH, clears counter
//   opcode      in   6      IR[31:26]
//   funct       in   6      IR[5:0]
//   zero        in   1      ALU zero flag
//   mem_ready   in   1      memory completes its access this cycle
//   iord        out  1      memory address: 0=PC, 1=ALUOut
//   memwrite    out  1      memory write strobe
//   irwrite     out  1      IR load enable
//   regdst      out  1      write register: 0=rt, 1=rd
//   memtoreg    out  1      write data: 0=ALUOut, 1=Data
//   regwrite    out  1      register file write enable
//   alusrca     out  1      ALU A: 0=PC, 1=A
//   alusrcb     out  2      ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//   pcsrc       out  2      PC next: 00=ALUResult, 01=ALUOut, 10=jump target
//   pcen        out  1      PC load enable
//   alucontrol  out  3      ALU operation select
//   illegal     out  1      pulse on unsupported opcode (DECODE) or funct (EXECUTE)
//   retired     out  CNT_W  completed-instruction counter, wraps
// ---------------------------------------------------------------------------
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  aluop_t           aluop;
  logic             pcwrite;
  logic             branch;
  logic             taken;
  logic             bad_funct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

`ifdef MC_BNE_EN
  // Remembers whether the branch being executed is a bne; captured in DECODE
  // because BRANCH alone cannot tell beq from bne.
  logic bne_q, bne_d;

  assign bne_d = (state_q == DECODE) ? (opcode == OP_BNE) : bne_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bne_q <= 1'b0;
    else       bne_q <= bne_d;
  end

  assign taken = bne_q ? ~zero : zero;
`else
  assign taken = zero;
`endif

  always_comb begin
    state_d  = state_q;
    aluop    = ALUOP_ADD;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // IR still holds the instruction, so the opcode selects load vs store.
        state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        illegal = bad_funct;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // An instruction retires when any execution state hands back to FETCH;
  // illegal opcodes leave from DECODE and are therefore not counted.
  always_comb begin
    retired_d = retired_q;
    if (state_q != FETCH && state_q != DECODE && state_d == FETCH)
      retired_d = retired_q + CNT_W'(1);
  end

  assign pcen    = pcwrite | (branch & taken);
  assign retired = retired_q;

  mc_alu_ctl u_alu_ctl (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol),
    .bad_funct_o  (bad_funct)
  );

endmodule
